// File: rtl/mc_avl_arb.sv
// Two-port Avalon-MM arbiter in front of the DDR controller command port, with read-return routing.
// Define MC_ARB_FIXED_PRIO_EN for fixed port-0 priority; default build is round-robin.
module mc_avl_arb #(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 128,
    parameter int RD_DEPTH = 8
) (
    input  logic                clkrst_mem_clk,
    input  logic                clkrst_mem_rst,
    input  logic [ADDR_W-1:0]   p0_avl_addr,
    input  logic [DATA_W/8-1:0] p0_avl_be,
    input  logic                p0_avl_burstbegin,
    input  logic                p0_avl_read_req,
    input  logic                p0_avl_write_req,
    input  logic [4:0]          p0_avl_size,
    input  logic [DATA_W-1:0]   p0_avl_wdata,
    output logic                p0_avl_ready,
    output logic [DATA_W-1:0]   p0_avl_rdata,
    output logic                p0_avl_rdata_valid,
    input  logic [ADDR_W-1:0]   p1_avl_addr,
    input  logic [DATA_W/8-1:0] p1_avl_be,
    input  logic                p1_avl_burstbegin,
    input  logic                p1_avl_read_req,
    input  logic                p1_avl_write_req,
    input  logic [4:0]          p1_avl_size,
    input  logic [DATA_W-1:0]   p1_avl_wdata,
    output logic                p1_avl_ready,
    output logic [DATA_W-1:0]   p1_avl_rdata,
    output logic                p1_avl_rdata_valid,
    output logic [ADDR_W-1:0]   mc_avl_addr,
    output logic [DATA_W/8-1:0] mc_avl_be,
    output logic                mc_avl_burstbegin,
    output logic                mc_avl_read_req,
    output logic                mc_avl_write_req,
    output logic [4:0]          mc_avl_size,
    output logic [DATA_W-1:0]   mc_avl_wdata,
    input  logic                mc_avl_ready,
    input  logic [DATA_W-1:0]   mc_avl_rdata,
    input  logic                mc_avl_rdata_valid,
    output logic                arb_err
);
    localparam int PTR_W = $clog2(RD_DEPTH);

`ifdef MC_ARB_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    typedef enum logic [0:0] {StIdle, StWburst} state_e;

    state_e     r_state, w_state_nxt;
    logic       r_rr_ptr, w_rr_nxt;
    logic       r_lock_port, w_lock_nxt;
    logic [4:0] r_beats_left, w_beats_nxt;
    logic [4:0] r_ret_cnt;
    logic       r_arb_err;
    logic [PTR_W:0] r_wr_ptr, r_rd_ptr;
    logic       r_fifo_port [RD_DEPTH];
    logic [4:0] r_fifo_size [RD_DEPTH];

    logic       w_req0, w_req1, w_gnt;
    logic       w_g_rd, w_g_wr, w_g_bb;
    logic [4:0] w_g_size;
    logic       w_fifo_full, w_fifo_empty;
    logic       w_is_rd, w_accept, w_rd_acc, w_wr_acc;
    logic       w_head_port, w_ret, w_pop;
    logic [4:0] w_head_size;

    assign w_req0 = p0_avl_read_req | p0_avl_write_req;
    assign w_req1 = p1_avl_read_req | p1_avl_write_req;

    // Locked grant during a write burst; otherwise combinational pick.
    always_comb begin
        if (r_state == StWburst) begin
            w_gnt = r_lock_port;
        end else if (w_req0 && w_req1) begin
            w_gnt = FixedPrio ? 1'b0 : r_rr_ptr;
        end else begin
            w_gnt = w_req1;
        end
    end

    assign w_g_rd   = w_gnt ? p1_avl_read_req   : p0_avl_read_req;
    assign w_g_wr   = w_gnt ? p1_avl_write_req  : p0_avl_write_req;
    assign w_g_bb   = w_gnt ? p1_avl_burstbegin : p0_avl_burstbegin;
    assign w_g_size = w_gnt ? p1_avl_size       : p0_avl_size;

    assign mc_avl_addr  = w_gnt ? p1_avl_addr  : p0_avl_addr;
    assign mc_avl_be    = w_gnt ? p1_avl_be    : p0_avl_be;
    assign mc_avl_wdata = w_gnt ? p1_avl_wdata : p0_avl_wdata;
    assign mc_avl_size  = (w_g_size == 5'd0) ? 5'd1 : w_g_size;

    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                          (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    assign w_is_rd           = (r_state == StIdle) && w_g_rd;
    assign mc_avl_read_req   = !clkrst_mem_rst && w_is_rd && !w_fifo_full;
    assign mc_avl_write_req  = !clkrst_mem_rst && w_g_wr && !w_is_rd;
    assign mc_avl_burstbegin = w_g_bb && (mc_avl_read_req || mc_avl_write_req);

    assign w_accept     = mc_avl_ready && (mc_avl_read_req || mc_avl_write_req);
    assign w_rd_acc     = w_accept && mc_avl_read_req;
    assign w_wr_acc     = w_accept && mc_avl_write_req;
    assign p0_avl_ready = w_accept && !w_gnt;
    assign p1_avl_ready = w_accept && w_gnt;

    assign w_head_port = r_fifo_port[r_rd_ptr[PTR_W-1:0]];
    assign w_head_size = r_fifo_size[r_rd_ptr[PTR_W-1:0]];
    assign w_ret       = mc_avl_rdata_valid && !clkrst_mem_rst && !w_fifo_empty;
    assign w_pop       = w_ret && ((r_ret_cnt + 5'd1) == w_head_size);

    assign p0_avl_rdata       = mc_avl_rdata;
    assign p1_avl_rdata       = mc_avl_rdata;
    assign p0_avl_rdata_valid = w_ret && !w_head_port;
    assign p1_avl_rdata_valid = w_ret && w_head_port;
    assign arb_err            = r_arb_err;

    always_comb begin
        w_state_nxt = r_state;
        w_beats_nxt = r_beats_left;
        w_lock_nxt  = r_lock_port;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            StIdle: begin
                if (w_wr_acc) begin
                    if (mc_avl_size > 5'd1) begin
                        w_state_nxt = StWburst;
                        w_beats_nxt = mc_avl_size - 5'd1;
                        w_lock_nxt  = w_gnt;
                    end else begin
                        w_rr_nxt = !w_gnt;
                    end
                end else if (w_rd_acc) begin
                    w_rr_nxt = !w_gnt;
                end
            end
            StWburst: begin
                if (w_wr_acc) begin
                    w_beats_nxt = r_beats_left - 5'd1;
                    if (r_beats_left == 5'd1) begin
                        w_state_nxt = StIdle;
                        w_rr_nxt    = !r_lock_port;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clkrst_mem_clk) begin
        if (clkrst_mem_rst) begin
            r_state      <= StIdle;
            r_rr_ptr     <= 1'b0;
            r_lock_port  <= 1'b0;
            r_beats_left <= 5'd0;
            r_ret_cnt    <= 5'd0;
            r_arb_err    <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_nxt;
            r_lock_port  <= w_lock_nxt;
            r_beats_left <= w_beats_nxt;
            if (w_rd_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_ret_cnt <= 5'd0;
            end else if (w_ret) begin
                r_ret_cnt <= r_ret_cnt + 5'd1;
            end
            if (mc_avl_rdata_valid && w_fifo_empty) begin
                r_arb_err <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clkrst_mem_clk) begin
        if (w_rd_acc) begin
            r_fifo_port[r_wr_ptr[PTR_W-1:0]] <= w_gnt;
            r_fifo_size[r_wr_ptr[PTR_W-1:0]] <= mc_avl_size;
        end
    end

endmodule

// File: doc/mc_avl_arb.md
# mc_avl_arb

Two-port arbiter sharing the single Avalon-MM command port of the DDR memory controller (`ltc2mc_avl_*_0`) between the LTC (port 0) and a secondary requester such as video scan-out or DMA (port 1). It locks the grant for the full length of a write burst, tracks outstanding reads in a tag FIFO, and routes each returning read beat to the port that issued it. It sits between `MCPU_int` requesters and the memory controller in the `clkrst_mem_clk` domain.

## Interface
- `ADDR_W`, 25, Avalon word address width
- `DATA_W`, 128, data width; byte-enable width is `DATA_W/8`
- `RD_DEPTH`, 8, outstanding-read tag FIFO depth (power of 2, ≥2)

Ports:
- `clkrst_mem_clk`  in  1  memory clock; all logic on rising edge
- `clkrst_mem_rst`  in  1  synchronous, active-high reset
- `pN_avl_addr` (N=0,1)  in  ADDR_W  requester address
- `pN_avl_be`  in  DATA_W/8  byte enables
- `pN_avl_burstbegin`  in  1  first beat of a command
- `pN_avl_read_req` / `pN_avl_write_req`  in  1  command strobes
- `pN_avl_size`  in  5  burst length in beats
- `pN_avl_wdata`  in  DATA_W  write data
- `pN_avl_ready`  out  1  beat/command accepted this cycle
- `pN_avl_rdata`  out  DATA_W  read data (shared copy of `mc_avl_rdata`)
- `pN_avl_rdata_valid`  out  1  read beat belongs to port N
- `mc_avl_addr`, `mc_avl_be`, `mc_avl_burstbegin`, `mc_avl_read_req`, `mc_avl_write_req`, `mc_avl_size`, `mc_avl_wdata`  out  as above  to controller
- `mc_avl_ready`  in  1  controller accepts
- `mc_avl_rdata`  in  DATA_W; `mc_avl_rdata_valid`  in  1  read return
- `arb_err`  out  1  sticky: read beat returned with tag FIFO empty

## Operation
- States: IDLE, WBURST. Grant is combinational in IDLE, registered (locked) in WBURST.
- IDLE grant: among ports with `read_req|write_req`, the one matching `rr_ptr` wins; otherwise the sole requester. Granted port's fields are muxed to `mc_avl_*`; the other port sees `ready=0`.
- Read accept: `read_req & mc_avl_ready & !fifo_full` -> push {port, size} to tag FIFO; `rr_ptr` <- other port. When FIFO full, `mc_avl_read_req` is forced 0 and `pN_avl_ready=0`.
- Write accept of first beat: `write_req & mc_avl_ready`. If size>1 -> WBURST, `beats_left` <- size-1, grant locked. If size==1, stay IDLE, flip `rr_ptr`.
- WBURST: only the locked port is muxed; each accepted beat decrements `beats_left`; on the final beat -> IDLE, flip `rr_ptr`. Other port's requests wait, never dropped.
- Size 0 is illegal and is treated as 1.
- Read return: each `mc_avl_rdata_valid` asserts `pN_avl_rdata_valid` for the head entry's port and increments `ret_cnt`; when `ret_cnt+1==size`, pop and clear `ret_cnt`. With FIFO empty, the beat is dropped and `arb_err` is set until reset.
- Simultaneous push and pop: allowed. `fifo_full` is evaluated before the pop, so a push into a full FIFO is blocked even if a pop occurs the same cycle.

## Timing
- Command path: combinational, 0 added cycles. Read-data path: combinational routing, 0 added cycles.
- Reset (sync, 1 cycle): state=IDLE, `rr_ptr`=0, FIFO empty, `ret_cnt`=0, `beats_left`=0, `arb_err`=0.
- While reset is high: `mc_avl_read_req`/`write_req`/`burstbegin`=0, all `pN_avl_ready`=0, all `pN_avl_rdata_valid`=0. Other `mc_avl_*` fields are don't-care.
- Reset mid-burst or with reads pending: state is discarded. Any beats returned after reset set `arb_err`.

## Configuration
- `MC_ARB_FIXED_PRIO_EN` defined: port 0 always wins in IDLE and `rr_ptr` is unused. Write-burst lock still applies.
- Not defined: round-robin as described above.

## Test plan
- Both ports issue a read (size 1) every cycle with `mc_avl_ready=1` -> grants alternate 0,1,0,1. Returned beats assert `p0`/`p1` `rdata_valid` in issue order.
- Port 1 writes a size-4 burst while port 0 requests a read on its second beat -> 4 consecutive port-1 beats, then the port-0 read in the next cycle.
- `RD_DEPTH=8`, 8 reads issued with no return -> 9th read sees `ready=0`. One beat returns with the 9th request pending -> that request is accepted the following cycle, not the same cycle.
- Port 0 read size 2 then port 1 read size 1; 3 return beats -> `p0,p0,p1` `rdata_valid`.
- `mc_avl_rdata_valid` pulse with the FIFO empty -> no `pN_avl_rdata_valid`, `arb_err`=1 until reset.
- Reset asserted mid-WBURST (2 beats left) -> next cycle IDLE with `rr_ptr`=0; port 0 is granted first. With `MC_ARB_FIXED_PRIO_EN`, port 0 wins every contested IDLE cycle.
